mc_ctrl: RTL and testbench

Multicycle control unit for the MIPS datapath. It latches no data itself. It sequences instruction fetch, decode, execute, memory and write-back, and produces the `ALUop` code and datapath select lines consumed by the ALU, register file, PC and memory port. It sits between the instruction register/memory handshake and the ALU, and consumes the ALU's `equal` flag to resolve branches.

---
 rtl/mc_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM. It sequences fetch, decode, execute,
// memory and write-back, and drives the ALU code plus the datapath selects.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [5:0]  mem_rdata_op,
    input  logic        mem_ack,
    input  logic        equal,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic [3:0]  ALUop,
    output logic        alu_x_sel,
    output logic [1:0]  alu_y_sel,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;
    typedef enum logic [2:0] {KAlu, KLoad, KStore, KBeq, KBne, KJump} kind_e;

    localparam logic [3:0] AluIdle = 4'hD;

    state_e      state_q, state_d;
    logic        illegal_q, illegal_d;

    logic        dec_legal;
    logic        dec_sys;
    kind_e       dec_kind;
    logic [3:0]  dec_op;
    logic        dec_xs;
    logic [1:0]  dec_ys;

    wire [5:0] opcode = instr[31:26];
    wire [5:0] funct  = instr[5:0];

    // Register fields and the reserved memory opcode tap are consumed by the datapath only.
    logic unused_bits;
    assign unused_bits = ^{mem_rdata_op, instr[25:6]};

    // Instruction decode: class, legality, ALU code and operand selects.
    always_comb begin
        dec_legal = 1'b1;
        dec_sys   = 1'b0;
        dec_kind  = KAlu;
        dec_op    = AluIdle;
        dec_xs    = 1'b0;
        dec_ys    = 2'd0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00: begin dec_op = 4'h0; dec_xs = 1'b1; dec_ys = 2'd3; end
                    6'h02: begin dec_op = 4'h2; dec_xs = 1'b1; dec_ys = 2'd3; end
                    6'h03: begin dec_op = 4'h1; dec_xs = 1'b1; dec_ys = 2'd3; end
                    6'h04: begin dec_op = 4'h0; dec_xs = 1'b1; end
                    6'h06: begin dec_op = 4'h2; dec_xs = 1'b1; end
                    6'h07: begin dec_op = 4'h1; dec_xs = 1'b1; end
                    6'h20, 6'h21: dec_op = 4'h5;
                    6'h22, 6'h23: dec_op = 4'h6;
                    6'h24: dec_op = 4'h7;
                    6'h25: dec_op = 4'h8;
                    6'h26: dec_op = 4'h9;
                    6'h27: dec_op = 4'hA;
                    6'h2A: dec_op = 4'hB;
                    6'h2B: dec_op = 4'hC;
                    6'h0C: dec_sys = 1'b1;
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin dec_op = 4'h5; dec_ys = 2'd1; end
            6'h0A: begin dec_op = 4'hB; dec_ys = 2'd1; end
            6'h0B: begin dec_op = 4'hC; dec_ys = 2'd1; end
            6'h0C: begin dec_op = 4'h7; dec_ys = 2'd2; end
            6'h0D: begin dec_op = 4'h8; dec_ys = 2'd2; end
            6'h0E: begin dec_op = 4'h9; dec_ys = 2'd2; end
            6'h23: dec_kind = KLoad;
            6'h2B: dec_kind = KStore;
            6'h04: dec_kind = KBeq;
            6'h05: dec_kind = KBne;
            6'h02: dec_kind = KJump;
            default: dec_legal = 1'b0;
        endcase
    end

    // State register and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            StFetch:  if (mem_ack) state_d = StDecode;
            StDecode: begin
                if (!dec_legal) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end else if (dec_sys) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (dec_kind)
                    KLoad, KStore:     state_d = StMem;
                    KBeq, KBne, KJump: state_d = StFetch;
                    default:           state_d = StWb;
                endcase
            end
            StMem:    if (mem_ack) state_d = (dec_kind == KLoad) ? StWb : StFetch;
            StWb:     state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    // Output decode; everything is forced idle while reset is held so requests
    // and write enables drop the moment rst_n falls.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        ALUop        = AluIdle;
        alu_x_sel    = 1'b0;
        alu_y_sel    = 2'd0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        halted       = 1'b0;
        illegal      = 1'b0;
        if (rst_n) begin
            case (state_q)
                StFetch: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ack;
                end
                StDecode: pc_write = dec_legal && !dec_sys;
                StExec: begin
                    case (dec_kind)
                        KBeq, KBne: begin
                            ALUop    = 4'h6;
                            pc_src   = 2'd1;
                            pc_write = (dec_kind == KBeq) ? equal : !equal;
                        end
                        KJump: begin
                            pc_write = 1'b1;
                            pc_src   = 2'd2;
                        end
                        KLoad, KStore: begin
                            ALUop     = 4'h5;
                            alu_y_sel = 2'd1;
                        end
                        default: begin
                            ALUop     = dec_op;
                            alu_x_sel = dec_xs;
                            alu_y_sel = dec_ys;
                        end
                    endcase
                end
                StMem: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (dec_kind == KStore);
                    ALUop        = 4'h5;
                end
                StWb: begin
                    reg_write  = 1'b1;
                    reg_dst    = (opcode == 6'h00);
                    mem_to_reg = (dec_kind == KLoad);
                end
                StHalt: begin
                    halted  = 1'b1;
                    illegal = illegal_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed instruction sequences; each cycle's expected output
// vector is queued by the stimulus and checked by an independent monitor.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [5:0]  mem_rdata_op = 6'h0;
    logic        mem_ack = 1'b0;
    logic        equal = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_write;
    logic [3:0]  ALUop;
    logic        alu_x_sel;
    logic [1:0]  alu_y_sel;
    logic        reg_write, reg_dst, mem_to_reg, pc_write;
    logic [1:0]  pc_src;
    logic        halted, illegal;

    int n_cmp = 0;
    int n_bad = 0;

    logic [18:0] exp_q[$];
    string       name_q[$];

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_rdata_op(mem_rdata_op),
        .mem_ack(mem_ack), .equal(equal), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .ALUop(ALUop),
        .alu_x_sel(alu_x_sel), .alu_y_sel(alu_y_sel), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_write(pc_write),
        .pc_src(pc_src), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {req,we,asel,irw,ALUop,xs,ys,rw,rd,m2r,pw,psrc,halted,illegal}
    function automatic logic [18:0] mk(input logic req, we, asel, irw, input logic [3:0] op,
                                       input logic xs, input logic [1:0] ys,
                                       input logic rw, rd, m2r, pw, input logic [1:0] ps,
                                       input logic h, il);
        return {req, we, asel, irw, op, xs, ys, rw, rd, m2r, pw, ps, h, il};
    endfunction

    function automatic logic [18:0] e_idle();
        return mk(0, 0, 0, 0, 4'hD, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0);
    endfunction
    function automatic logic [18:0] e_fetch(input logic ack);
        return mk(1, 0, 0, ack, 4'hD, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0);
    endfunction
    function automatic logic [18:0] e_dec_ok();
        return mk(0, 0, 0, 0, 4'hD, 0, 2'd0, 0, 0, 0, 1, 2'd0, 0, 0);
    endfunction
    function automatic logic [18:0] e_exec(input logic [3:0] op, input logic xs,
                                           input logic [1:0] ys);
        return mk(0, 0, 0, 0, op, xs, ys, 0, 0, 0, 0, 2'd0, 0, 0);
    endfunction
    function automatic logic [18:0] e_br(input logic pw);
        return mk(0, 0, 0, 0, 4'h6, 0, 2'd0, 0, 0, 0, pw, 2'd1, 0, 0);
    endfunction
    function automatic logic [18:0] e_mem(input logic we);
        return mk(1, we, 1, 0, 4'h5, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0);
    endfunction
    function automatic logic [18:0] e_wb(input logic rd, input logic m2r);
        return mk(0, 0, 0, 0, 4'hD, 0, 2'd0, 1, rd, m2r, 0, 2'd0, 0, 0);
    endfunction
    function automatic logic [18:0] e_halt(input logic il);
        return mk(0, 0, 0, 0, 4'hD, 0, 2'd0, 0, 0, 0, 0, 2'd0, 1, il);
    endfunction

    // One cycle: drive inputs just after the edge and queue the expected outputs.
    task automatic step(input string nm, input logic rst, input logic [31:0] i,
                        input logic ack, input logic eq, input logic [18:0] x);
        @(posedge clk);
        #1;
        rst_n   = rst;
        instr   = i;
        mem_ack = ack;
        equal   = eq;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic run_alu(input string nm, input logic [31:0] i, input logic [3:0] op,
                           input logic xs, input logic [1:0] ys, input logic rd);
        step({nm, "_fetch"}, 1, i, 1, 0, e_fetch(1));
        step({nm, "_decode"}, 1, i, 0, 0, e_dec_ok());
        step({nm, "_exec"}, 1, i, 0, 0, e_exec(op, xs, ys));
        step({nm, "_wb"}, 1, i, 0, 0, e_wb(rd, 0));
    endtask

    task automatic run_branch(input string nm, input logic [31:0] i, input logic eq,
                              input logic pw);
        step({nm, "_fetch"}, 1, i, 1, 0, e_fetch(1));
        step({nm, "_decode"}, 1, i, 0, 0, e_dec_ok());
        step({nm, "_exec"}, 1, i, 0, eq, e_br(pw));
    endtask

    // Monitor: compare the sampled outputs mid-cycle against the queued expectation.
    initial begin
        logic [18:0] act;
        logic [18:0] exp_v;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act   = {mem_req, mem_we, mem_addr_sel, ir_write, ALUop, alu_x_sel, alu_y_sel,
                         reg_write, reg_dst, mem_to_reg, pc_write, pc_src, halted, illegal};
                n_cmp++;
                if (act !== exp_v) begin
                    n_bad++;
                    $display("FAIL %s: got %b want %b", nm, act, exp_v);
                end
            end
        end
    end

    initial begin
        // Reset held, even with a stray ack: everything idle.
        step("reset0", 0, 32'h0, 1, 0, e_idle());
        step("reset1", 0, 32'h0, 0, 0, e_idle());

        // add $3,$1,$2 then back in FETCH at cycle 5.
        run_alu("add", 32'h00221820, 4'h5, 0, 2'd0, 1);
        step("add_next_fetch", 1, 32'h00221820, 0, 0, e_fetch(0));

        run_alu("sll", 32'h00011100, 4'h0, 1, 2'd3, 1);
        run_alu("srav", 32'h00221807, 4'h1, 1, 2'd0, 1);
        run_alu("ori", 32'h34410005, 4'h8, 0, 2'd2, 0);
        run_alu("slti", 32'h28410005, 4'hB, 0, 2'd1, 0);

        // lw $1,8($2) with three wait cycles in MEM: 8 cycles total.
        step("lw_fetch", 1, 32'h8C410008, 1, 0, e_fetch(1));
        step("lw_decode", 1, 32'h8C410008, 0, 0, e_dec_ok());
        step("lw_exec", 1, 32'h8C410008, 0, 0, e_exec(4'h5, 0, 2'd1));
        for (int k = 0; k < 3; k++) step("lw_mem_wait", 1, 32'h8C410008, 0, 0, e_mem(0));
        step("lw_mem_ack", 1, 32'h8C410008, 1, 0, e_mem(0));
        step("lw_wb", 1, 32'h8C410008, 0, 0, e_wb(0, 1));

        // Branches: beq taken/not, bne inverse.
        run_branch("beq_eq1", 32'h10220003, 1, 1);
        run_branch("beq_eq0", 32'h10220003, 0, 0);
        run_branch("bne_eq1", 32'h14220003, 1, 0);
        run_branch("bne_eq0", 32'h14220003, 0, 1);

        // j
        step("j_fetch", 1, 32'h08000010, 1, 0, e_fetch(1));
        step("j_decode", 1, 32'h08000010, 0, 0, e_dec_ok());
        step("j_exec", 1, 32'h08000010, 0, 0,
             mk(0, 0, 0, 0, 4'hD, 0, 2'd0, 0, 0, 0, 1, 2'd2, 0, 0));

        // sw with one wait cycle.
        step("sw_fetch", 1, 32'hAC410008, 1, 0, e_fetch(1));
        step("sw_decode", 1, 32'hAC410008, 0, 0, e_dec_ok());
        step("sw_exec", 1, 32'hAC410008, 0, 0, e_exec(4'h5, 0, 2'd1));
        step("sw_mem_wait", 1, 32'hAC410008, 0, 0, e_mem(1));
        step("sw_mem_ack", 1, 32'hAC410008, 1, 0, e_mem(1));
        step("sw_next_fetch", 1, 32'h0, 0, 0, e_fetch(0));

        // sw aborted by reset during the MEM wait.
        step("swr_fetch", 1, 32'hAC410008, 1, 0, e_fetch(1));
        step("swr_decode", 1, 32'hAC410008, 0, 0, e_dec_ok());
        step("swr_exec", 1, 32'hAC410008, 0, 0, e_exec(4'h5, 0, 2'd1));
        step("swr_mem_wait", 1, 32'hAC410008, 0, 0, e_mem(1));
        step("swr_reset_drop", 0, 32'hAC410008, 0, 0, e_idle());
        step("swr_reset_hold", 0, 32'hAC410008, 1, 0, e_idle());
        step("swr_refetch", 1, 32'hAC410008, 0, 0, e_fetch(0));

        // Illegal opcode 0x3F: halt with illegal, no further requests.
        step("ill_fetch", 1, 32'hFC000000, 1, 0, e_fetch(1));
        step("ill_decode", 1, 32'hFC000000, 0, 0, e_idle());
        for (int k = 0; k < 3; k++) step("ill_halt", 1, 32'h00221820, 1, 0, e_halt(1));

        // syscall after reset: halt without illegal.
        step("sys_reset", 0, 32'h0, 0, 0, e_idle());
        step("sys_fetch", 1, 32'h0000000C, 1, 0, e_fetch(1));
        step("sys_decode", 1, 32'h0000000C, 0, 0, e_idle());
        for (int k = 0; k < 2; k++) step("sys_halt", 1, 32'hFC000000, 1, 0, e_halt(0));

        @(posedge clk);
        @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
